// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and data access onto one memory device port.
// Ports: clk/rst; instr_* and data_* requesters; busy/timeout_err status;
// dev_mem_* device side (req strobe, latched addr/data/dir, busy, read data).
module mem_arbiter #(
  parameter int MAX_DATA_BURST = 4,
  parameter int TIMEOUT        = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_req,
  input  logic [31:0] instr_addr,
  output logic [31:0] instr_rdata,
  output logic        instr_ready,
  input  logic        data_req,
  input  logic        data_is_write,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_ready,
  output logic        busy,
  output logic        timeout_err,
  output logic        dev_mem_req,
  output logic [31:0] dev_mem_addr,
  output logic [31:0] dev_mem_data_out,
  output logic        dev_mem_is_write,
  input  logic [31:0] dev_mem_data_in,
  input  logic        dev_mem_busy
);

  localparam int BW = $clog2(MAX_DATA_BURST + 1);
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_DATA_BURST);
  localparam logic [CW-1:0] WAIT_MAX  = CW'(TIMEOUT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  localparam logic OWN_INSTR = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  logic [1:0]    r_state;
  logic          r_owner;
  logic [BW-1:0] r_burst;
  logic [CW-1:0] r_wcnt;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic          r_is_write;
  logic [31:0]   r_instr_rdata;
  logic [31:0]   r_data_rdata;

  logic          w_idle;
  logic          w_issue;
  logic          w_wait;
  logic          w_any_req;
  logic          w_burst_full;
  logic          w_grant_instr;
  logic [BW-1:0] w_burst_nxt;
  logic          w_done;
  logic          w_abort;

  assign w_idle  = (r_state == S_IDLE);
  assign w_issue = (r_state == S_ISSUE);
  assign w_wait  = (r_state == S_WAIT);

  assign w_any_req    = instr_req | data_req;
  assign w_burst_full = (r_burst == BURST_MAX);

  // Data normally wins; a starved fetch wins once the burst limit is hit.
  assign w_grant_instr = instr_req & (~data_req | w_burst_full);

  // Burst only counts data grants that made a waiting fetch wait longer.
  always_comb begin
    w_burst_nxt = '0;
    if (instr_req) begin
      w_burst_nxt = w_burst_full ? r_burst : r_burst + BW'(1);
    end
  end

  assign w_done  = w_wait & ~dev_mem_busy;
  assign w_abort = w_wait & dev_mem_busy & (r_wcnt == WAIT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_owner       <= OWN_INSTR;
      r_burst       <= '0;
      r_wcnt        <= '0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_is_write    <= 1'b0;
      r_instr_rdata <= '0;
      r_data_rdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_state <= S_ISSUE;
            if (w_grant_instr) begin
              r_owner    <= OWN_INSTR;
              r_addr     <= instr_addr;
              r_wdata    <= '0;
              r_is_write <= 1'b0;
              r_burst    <= '0;
            end else begin
              r_owner    <= OWN_DATA;
              r_addr     <= data_addr;
              r_wdata    <= data_wdata;
              r_is_write <= data_is_write;
              r_burst    <= w_burst_nxt;
            end
          end
        end
        S_ISSUE: begin
          r_state <= S_WAIT;
          r_wcnt  <= '0;
        end
        S_WAIT: begin
          if (w_done) begin
            r_state <= S_IDLE;
            if (r_owner == OWN_INSTR) begin
              r_instr_rdata <= dev_mem_data_in;
            end else if (!r_is_write) begin
              r_data_rdata <= dev_mem_data_in;
            end
          end else if (w_abort) begin
            r_state <= S_IDLE;
          end else begin
            r_wcnt <= r_wcnt + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Strobes are masked while rst is high so an abandoned
  // transaction never signals completion, abort or a new start.
  assign busy        = ~w_idle;
  assign dev_mem_req = w_issue & ~rst;
  assign instr_ready = w_done & (r_owner == OWN_INSTR) & ~rst;
  assign data_ready  = w_done & (r_owner == OWN_DATA) & ~rst;
  assign timeout_err = w_abort & ~rst;

  // Read data is visible in the ready cycle itself, then held.
  assign instr_rdata = instr_ready ? dev_mem_data_in : r_instr_rdata;
  assign data_rdata  = (data_ready & ~r_is_write) ? dev_mem_data_in
                                                  : r_data_rdata;

  assign dev_mem_addr     = r_addr;
  assign dev_mem_data_out = r_wdata;
  assign dev_mem_is_write = r_is_write;

endmodule
